// File: rtl/rv32_fxmadd_pipe_unit_if.sv
// Handshake and data bundle for the fixed-point multiply-shift-add unit.
// The master issues ops and takes results; the slave is the unit itself.
interface rv32_fxmadd_pipe_unit_if #(
   parameter int XLEN    = 32,
   parameter int SCALE_W = $clog2(2*XLEN),
   parameter int TAG_W   = 5
);
   logic               in_valid;
   logic               in_ready;
   logic [XLEN-1:0]    mul_op_1;
   logic [XLEN-1:0]    mul_op_2;
   logic [XLEN-1:0]    add_op;
   logic [SCALE_W-1:0] scale;
   logic               round_en;
   logic               sat_en;
   logic [TAG_W-1:0]   in_tag;
   logic               out_valid;
   logic               out_ready;
   logic [XLEN-1:0]    result;
   logic [TAG_W-1:0]   out_tag;
   logic               overflow;

   modport master (
      output in_valid, mul_op_1, mul_op_2, add_op, scale, round_en, sat_en, in_tag, out_ready,
      input  in_ready, out_valid, result, out_tag, overflow
   );

   modport slave (
      input  in_valid, mul_op_1, mul_op_2, add_op, scale, round_en, sat_en, in_tag, out_ready,
      output in_ready, out_valid, result, out_tag, overflow
   );
endinterface

// File: rtl/rv32_fxmadd_pipe_unit.sv
// Three-stage pipelined ((a*b) >>> scale) + c with optional rounding and saturation.
// Stages: S1 holds the product, S2 the rounded/shifted value, S3 the final result.
module rv32_fxmadd_pipe_unit #(
   parameter int XLEN         = 32,
   parameter int SCALE_W      = $clog2(2*XLEN),
   parameter int TAG_W        = 5,
   parameter bit LEGACY_TRUNC = 1'b0
) (
   input logic                    clk,
   input logic                    resetn,
   input logic                    flush,
   rv32_fxmadd_pipe_unit_if.slave bus
);
   localparam int PW = 2*XLEN;
   localparam int RW = 2*XLEN + 1;
   localparam int SW = 2*XLEN + 2;

   logic s1_valid, s2_valid, s3_valid;
   logic adv1, adv2, adv3, accept;

   logic signed [PW-1:0] s1_prod;
   logic [XLEN-1:0]      s1_c;
   logic [SCALE_W-1:0]   s1_scale;
   logic                 s1_round, s1_sat;
   logic [TAG_W-1:0]     s1_tag;

   logic signed [RW-1:0] s2_shifted;
   logic [XLEN-1:0]      s2_c;
   logic                 s2_sat;
   logic [TAG_W-1:0]     s2_tag;

   logic [XLEN-1:0]      s3_result;
   logic                 s3_ovf;
   logic [TAG_W-1:0]     s3_tag;

   logic signed [PW-1:0] full_prod, mul_prod;
   logic signed [RW-1:0] rnd_bias, rnd_in, shifted;
   logic signed [SW-1:0] sum;
   logic                 sum_ovf;
   logic [XLEN-1:0]      final_res;

   // Each stage moves forward when the stage after it is empty or draining itself.
   assign adv3   = s3_valid && bus.out_ready;
   assign adv2   = s2_valid && (!s3_valid || adv3);
   assign adv1   = s1_valid && (!s2_valid || adv2);
   assign bus.in_ready = !flush && (!s1_valid || adv1);
   assign accept = bus.in_valid && bus.in_ready;

   assign full_prod = $signed({{XLEN{bus.mul_op_1[XLEN-1]}}, bus.mul_op_1}) *
                      $signed({{XLEN{bus.mul_op_2[XLEN-1]}}, bus.mul_op_2});
   assign mul_prod  = LEGACY_TRUNC ? {{XLEN{full_prod[XLEN-1]}}, full_prod[XLEN-1:0]} : full_prod;

   always_comb begin
      rnd_bias = '0;
      if (s1_round && (s1_scale != '0)) begin
         rnd_bias = RW'(1) << (s1_scale - 1'b1);
      end
      rnd_in  = {s1_prod[PW-1], s1_prod} + rnd_bias;
      shifted = rnd_in >>> s1_scale;
   end

   // The sum fits in SW bits; it fits XLEN only when the bits above the XLEN sign agree with it.
   always_comb begin
      sum       = {s2_shifted[RW-1], s2_shifted} + {{(XLEN+2){s2_c[XLEN-1]}}, s2_c};
      sum_ovf   = sum[SW-1:XLEN-1] != {(SW-XLEN+1){sum[XLEN-1]}};
      final_res = sum[XLEN-1:0];
      if (s2_sat && sum_ovf) begin
         final_res = sum[SW-1] ? {1'b1, {(XLEN-1){1'b0}}} : {1'b0, {(XLEN-1){1'b1}}};
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
         s3_valid <= 1'b0;
      end else if (flush) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
         s3_valid <= 1'b0;
      end else begin
         s1_valid <= accept || (s1_valid && !adv1);
         s2_valid <= adv1   || (s2_valid && !adv2);
         s3_valid <= adv2   || (s3_valid && !adv3);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         s1_prod    <= '0;
         s1_c       <= '0;
         s1_scale   <= '0;
         s1_round   <= 1'b0;
         s1_sat     <= 1'b0;
         s1_tag     <= '0;
         s2_shifted <= '0;
         s2_c       <= '0;
         s2_sat     <= 1'b0;
         s2_tag     <= '0;
         s3_result  <= '0;
         s3_ovf     <= 1'b0;
         s3_tag     <= '0;
      end else if (!flush) begin
         if (accept) begin
            s1_prod  <= mul_prod;
            s1_c     <= bus.add_op;
            s1_scale <= bus.scale;
            s1_round <= bus.round_en;
            s1_sat   <= bus.sat_en;
            s1_tag   <= bus.in_tag;
         end
         if (adv1) begin
            s2_shifted <= shifted;
            s2_c       <= s1_c;
            s2_sat     <= s1_sat;
            s2_tag     <= s1_tag;
         end
         if (adv2) begin
            s3_result <= final_res;
            s3_ovf    <= sum_ovf;
            s3_tag    <= s2_tag;
         end
      end
   end

   assign bus.out_valid = s3_valid;
   assign bus.result    = s3_result;
   assign bus.out_tag   = s3_tag;
   assign bus.overflow  = s3_ovf;
endmodule

// File: tb/tb_rv32_fxmadd_pipe_unit.sv
// Directed bench for rv32_fxmadd_pipe_unit: vector table plus backpressure, flush and reset sequences.
// A second instance built with LEGACY_TRUNC=1 sees the same stimulus.
module tb_rv32_fxmadd_pipe_unit;
   localparam int XLEN    = 32;
   localparam int SCALE_W = 6;
   localparam int TAG_W   = 5;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] c;
      logic [5:0]  sc;
      logic        rnd;
      logic        sat;
      logic [31:0] exp_res;
      logic        exp_ovf;
      logic [31:0] exp_leg;
      logic        exp_leg_ovf;
   } vec_t;

   logic clk = 1'b0;
   logic resetn;
   logic flush;
   int   total = 0;
   int   bad   = 0;
   vec_t vecs[16];

   always #5 clk = ~clk;

   rv32_fxmadd_pipe_unit_if #(.XLEN(XLEN), .SCALE_W(SCALE_W), .TAG_W(TAG_W)) bus ();
   rv32_fxmadd_pipe_unit_if #(.XLEN(XLEN), .SCALE_W(SCALE_W), .TAG_W(TAG_W)) lbus ();

   assign lbus.in_valid  = bus.in_valid;
   assign lbus.mul_op_1  = bus.mul_op_1;
   assign lbus.mul_op_2  = bus.mul_op_2;
   assign lbus.add_op    = bus.add_op;
   assign lbus.scale     = bus.scale;
   assign lbus.round_en  = bus.round_en;
   assign lbus.sat_en    = bus.sat_en;
   assign lbus.in_tag    = bus.in_tag;
   assign lbus.out_ready = bus.out_ready;

   rv32_fxmadd_pipe_unit #(.XLEN(XLEN), .SCALE_W(SCALE_W), .TAG_W(TAG_W), .LEGACY_TRUNC(1'b0)) dut (
      .clk(clk), .resetn(resetn), .flush(flush), .bus(bus)
   );

   rv32_fxmadd_pipe_unit #(.XLEN(XLEN), .SCALE_W(SCALE_W), .TAG_W(TAG_W), .LEGACY_TRUNC(1'b1)) dut_legacy (
      .clk(clk), .resetn(resetn), .flush(flush), .bus(lbus)
   );

   task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s got=0x%08h exp=0x%08h", name, got, exp);
      end
   endtask

   task automatic apply_stimulus(input vec_t v, input logic [TAG_W-1:0] tag);
      bus.mul_op_1 = v.a;
      bus.mul_op_2 = v.b;
      bus.add_op   = v.c;
      bus.scale    = v.sc;
      bus.round_en = v.rnd;
      bus.sat_en   = v.sat;
      bus.in_tag   = tag;
      bus.in_valid = 1'b1;
   endtask

   // One isolated op: issue, wait (bounded) for the result, and check latency and every output.
   task automatic run_vector(input vec_t v, input logic [TAG_W-1:0] tag, input string label);
      int lat;
      @(negedge clk);
      apply_stimulus(v, tag);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      lat = 1;
      while (!bus.out_valid && lat < 10) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check_output($sformatf("%s latency", label), 32'(lat), 32'd3);
      check_output($sformatf("%s result", label), bus.result, v.exp_res);
      check_output($sformatf("%s overflow", label), {31'd0, bus.overflow}, {31'd0, v.exp_ovf});
      check_output($sformatf("%s tag", label), {27'd0, bus.out_tag}, {27'd0, tag});
      check_output($sformatf("%s legacy result", label), lbus.result, v.exp_leg);
      check_output($sformatf("%s legacy overflow", label), {31'd0, lbus.overflow}, {31'd0, v.exp_leg_ovf});
      @(posedge clk);
      @(posedge clk);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      vec_t bp;
      int   issued;
      int   drained;
      int   seen;
      logic acc;

      vecs[0]  = '{32'd3,        32'd5,        32'd7,        6'd0,  1'b0, 1'b0, 32'd22,       1'b0, 32'd22,       1'b0};
      vecs[1]  = '{32'h00018000, 32'h00020000, 32'd0,        6'd16, 1'b0, 1'b0, 32'h00030000, 1'b0, 32'h00000000, 1'b0};
      vecs[2]  = '{32'd3,        32'd1,        32'd0,        6'd1,  1'b1, 1'b0, 32'd2,        1'b0, 32'd2,        1'b0};
      vecs[3]  = '{32'd3,        32'd1,        32'd0,        6'd1,  1'b0, 1'b0, 32'd1,        1'b0, 32'd1,        1'b0};
      vecs[4]  = '{32'hFFFFFFFD, 32'd1,        32'd0,        6'd1,  1'b1, 1'b0, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF, 1'b0};
      vecs[5]  = '{32'hFFFFFFFD, 32'd1,        32'd0,        6'd1,  1'b0, 1'b0, 32'hFFFFFFFE, 1'b0, 32'hFFFFFFFE, 1'b0};
      vecs[6]  = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'd0,        6'd0,  1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 32'h00000001, 1'b0};
      vecs[7]  = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'd0,        6'd0,  1'b0, 1'b0, 32'h00000001, 1'b1, 32'h00000001, 1'b0};
      vecs[8]  = '{32'h80000000, 32'd1,        32'hFFFFFFFF, 6'd0,  1'b0, 1'b1, 32'h80000000, 1'b1, 32'h80000000, 1'b1};
      vecs[9]  = '{32'h80000000, 32'd1,        32'hFFFFFFFF, 6'd0,  1'b0, 1'b0, 32'h7FFFFFFF, 1'b1, 32'h7FFFFFFF, 1'b1};
      vecs[10] = '{32'hFFFFFFF9, 32'd6,        32'd100,      6'd2,  1'b1, 1'b0, 32'd90,       1'b0, 32'd90,       1'b0};
      vecs[11] = '{32'h00010000, 32'h00010000, 32'd5,        6'd32, 1'b0, 1'b0, 32'd6,        1'b0, 32'd5,        1'b0};
      vecs[12] = '{32'hFFFFFFFF, 32'd1,        32'd0,        6'd63, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF, 1'b0};
      vecs[13] = '{32'hFFFFFFFF, 32'd1,        32'd0,        6'd63, 1'b1, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 1'b0};
      vecs[14] = '{32'hFFFFFFFB, 32'd4,        32'hFFFFFFFD, 6'd0,  1'b0, 1'b1, 32'hFFFFFFE9, 1'b0, 32'hFFFFFFE9, 1'b0};
      vecs[15] = '{32'h00018000, 32'd1,        32'd0,        6'd16, 1'b1, 1'b0, 32'd2,        1'b0, 32'd2,        1'b0};

      resetn        = 1'b0;
      flush         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.mul_op_1  = '0;
      bus.mul_op_2  = '0;
      bus.add_op    = '0;
      bus.scale     = '0;
      bus.round_en  = 1'b0;
      bus.sat_en    = 1'b0;
      bus.in_tag    = '0;
      bus.out_ready = 1'b1;

      #1;
      check_output("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
      check_output("reset result", bus.result, 32'd0);
      check_output("reset overflow", {31'd0, bus.overflow}, 32'd0);
      check_output("reset out_tag", {27'd0, bus.out_tag}, 32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      resetn = 1'b1;
      #1;
      check_output("release in_ready", {31'd0, bus.in_ready}, 32'd1);

      for (int i = 0; i < 16; i++) begin
         run_vector(vecs[i], TAG_W'(i + 1), $sformatf("vec%0d", i));
      end

      // Six back-to-back ops with the consumer stalled in cycles 4..6.
      issued  = 0;
      drained = 0;
      for (int cyc = 1; cyc <= 20; cyc++) begin
         @(negedge clk);
         bus.out_ready = !(cyc >= 4 && cyc <= 6);
         if (issued < 6) begin
            bp = '{32'(issued + 1), 32'd10, 32'(issued), 6'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0};
            apply_stimulus(bp, TAG_W'(16 + issued));
         end else begin
            bus.in_valid = 1'b0;
         end
         #1;
         if (cyc >= 4 && cyc <= 6) begin
            check_output($sformatf("bp stall c%0d in_ready", cyc), {31'd0, bus.in_ready}, 32'd0);
            check_output($sformatf("bp stall c%0d out_valid", cyc), {31'd0, bus.out_valid}, 32'd1);
            check_output($sformatf("bp stall c%0d result", cyc), bus.result, 32'd10);
            check_output($sformatf("bp stall c%0d tag", cyc), {27'd0, bus.out_tag}, 32'd16);
            check_output($sformatf("bp stall c%0d overflow", cyc), {31'd0, bus.overflow}, 32'd0);
         end
         if (cyc == 7) begin
            check_output("bp full drain in_ready", {31'd0, bus.in_ready}, 32'd1);
         end
         if (bus.out_valid && bus.out_ready) begin
            if (drained < 6) begin
               check_output($sformatf("bp op%0d result", drained), bus.result, 32'(11 * drained + 10));
               check_output($sformatf("bp op%0d tag", drained), {27'd0, bus.out_tag}, 32'(16 + drained));
            end
            drained++;
         end
         acc = bus.in_valid && bus.in_ready;
         @(posedge clk);
         if (acc) issued++;
      end
      bus.in_valid = 1'b0;
      check_output("bp issued count", 32'(issued), 32'd6);
      check_output("bp drained count", 32'(drained), 32'd6);

      // Fill the pipe with three stalled ops, then flush while offering a fourth.
      bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         apply_stimulus(vecs[i], TAG_W'(20 + i));
         @(posedge clk);
      end
      @(negedge clk);
      apply_stimulus(vecs[3], TAG_W'(30));
      flush = 1'b1;
      #1;
      check_output("flush full out_valid", {31'd0, bus.out_valid}, 32'd1);
      check_output("flush in_ready", {31'd0, bus.in_ready}, 32'd0);
      @(posedge clk);
      #1;
      check_output("flush out_valid", {31'd0, bus.out_valid}, 32'd0);
      @(negedge clk);
      flush         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) seen++;
      end
      check_output("flush leftover outputs", 32'(seen), 32'd0);
      run_vector(vecs[0], TAG_W'(7), "post-flush");

      // Hold an overflowing result, then pull reset low mid-stream.
      bus.out_ready = 1'b0;
      @(negedge clk);
      apply_stimulus(vecs[6], TAG_W'(9));
      @(posedge clk);
      @(negedge clk);
      apply_stimulus(vecs[0], TAG_W'(10));
      seen = 0;
      while (!bus.out_valid && seen < 10) begin
         @(posedge clk);
         #1;
         bus.in_valid = 1'b0;
         seen++;
      end
      check_output("pre-reset result", bus.result, 32'h7FFFFFFF);
      check_output("pre-reset overflow", {31'd0, bus.overflow}, 32'd1);
      @(negedge clk);
      resetn = 1'b0;
      #1;
      check_output("async reset out_valid", {31'd0, bus.out_valid}, 32'd0);
      check_output("async reset result", bus.result, 32'd0);
      check_output("async reset overflow", {31'd0, bus.overflow}, 32'd0);
      check_output("async reset out_tag", {27'd0, bus.out_tag}, 32'd0);
      bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      resetn = 1'b1;
      #1;
      check_output("re-release in_ready", {31'd0, bus.in_ready}, 32'd1);
      seen = 0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) seen++;
      end
      check_output("post-reset leftover outputs", 32'(seen), 32'd0);
      run_vector(vecs[10], TAG_W'(11), "post-reset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
